// File: rtl/ring_checker.sv
// Ring counter receive-side monitor: locks onto a rotating pattern, tracks its
// position and revolutions, and flags any sample that is not one rotation of the last.
module ring_checker #(
   parameter int WIDTH    = 4,
   parameter bit ROT_LEFT = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           din,
   input  logic                       in_valid,
   output logic                       locked,
   output logic [$clog2(WIDTH)-1:0]   pos,
   output logic [7:0]                 rev_count,
   output logic                       err,
   output logic [7:0]                 err_count
);

   localparam int PW = $clog2(WIDTH);
   localparam logic [PW-1:0] POS_LAST = PW'(WIDTH - 1);

   typedef enum logic {HUNT, TRACK} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] ref_reg;
   logic [WIDTH-1:0] exp_rot;
   logic             degenerate;
   logic             pos_last;

   // Expected next sample: each bit is taken from its neighbour in the rotation direction.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
         localparam int SRC = ROT_LEFT ? ((gi + WIDTH - 1) % WIDTH) : ((gi + 1) % WIDTH);
         assign exp_rot[gi] = ref_reg[SRC];
      end
   endgenerate

   assign degenerate = (din == '0) || (din == '1);
   assign pos_last   = (pos == POS_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= HUNT;
         ref_reg   <= '0;
         locked    <= 1'b0;
         pos       <= '0;
         rev_count <= 8'd0;
         err       <= 1'b0;
         err_count <= 8'd0;
      end else begin
         err <= 1'b0;
         if (in_valid) begin
            case (state_reg)
               HUNT: begin
                  // All-zero/all-ones patterns look identical under rotation, so they cannot anchor a lock.
                  if (!degenerate) begin
                     ref_reg   <= din;
                     pos       <= '0;
                     locked    <= 1'b1;
                     state_reg <= TRACK;
                  end
               end
               TRACK: begin
                  if (din == exp_rot) begin
                     ref_reg <= din;
                     if (pos_last) begin
                        pos       <= '0;
                        rev_count <= rev_count + 8'd1;
                     end else begin
                        pos <= pos + PW'(1);
                     end
                  end else begin
                     err <= 1'b1;
                     if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                     pos <= '0;
                     if (degenerate) begin
                        ref_reg   <= '0;
                        locked    <= 1'b0;
                        state_reg <= HUNT;
                     end else begin
                        ref_reg <= din;
                     end
                  end
               end
               default: state_reg <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ring_checker.sv
// Directed bench for ring_checker: one left-rotating and one right-rotating instance,
// expectations queued per step and compared one cycle later.
module tb_ring_checker;

   localparam bit L = 1'b0;
   localparam bit R = 1'b1;

   logic       clk;
   logic       reset;
   logic [3:0] din;
   logic       in_valid;

   logic       locked_l, err_l, locked_r, err_r;
   logic [1:0] pos_l, pos_r;
   logic [7:0] rev_l, ec_l, rev_r, ec_r;

   int passed = 0;
   int total  = 0;
   int step_no = 0;

   typedef struct {
      bit   sel;
      logic lk;
      int   pos;
      int   rev;
      logic err;
      int   ec;
   } exp_t;

   exp_t sb[$];

   ring_checker #(.WIDTH(4), .ROT_LEFT(1'b1)) dut_l (
      .clk(clk), .reset(reset), .din(din), .in_valid(in_valid),
      .locked(locked_l), .pos(pos_l), .rev_count(rev_l), .err(err_l), .err_count(ec_l)
   );

   ring_checker #(.WIDTH(4), .ROT_LEFT(1'b0)) dut_r (
      .clk(clk), .reset(reset), .din(din), .in_valid(in_valid),
      .locked(locked_r), .pos(pos_r), .rev_count(rev_r), .err(err_r), .err_count(ec_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog step=%0d observed=timeout expected=finish", step_no);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, expv);
   endtask

   task automatic step(input bit rst, input logic [3:0] d, input logic v, input bit sel,
                       input logic lk, input int p, input int rv, input logic e, input int ec);
      exp_t x;
      logic       o_lk, o_err;
      logic [1:0] o_pos;
      logic [7:0] o_rev, o_ec;
      x.sel = sel; x.lk = lk; x.pos = p; x.rev = rv; x.err = e; x.ec = ec;
      sb.push_back(x);
      reset = rst; din = d; in_valid = v;
      @(posedge clk);
      #1;
      step_no++;
      x = sb.pop_front();
      if (x.sel == R) begin
         o_lk = locked_r; o_pos = pos_r; o_rev = rev_r; o_err = err_r; o_ec = ec_r;
      end else begin
         o_lk = locked_l; o_pos = pos_l; o_rev = rev_l; o_err = err_l; o_ec = ec_l;
      end
      $display("step %0d dut=%s rst=%0d din=%b v=%0d locked=%0d pos=%0d rev=%0d err=%0d ec=%0d",
               step_no, x.sel ? "right" : "left", rst, d, v, o_lk, o_pos, o_rev, o_err, o_ec);
      chk("locked", {31'd0, o_lk}, {31'd0, x.lk});
      chk("pos", {30'd0, o_pos}, x.pos);
      chk("rev_count", {24'd0, o_rev}, x.rev);
      chk("err", {31'd0, o_err}, {31'd0, x.err});
      chk("err_count", {24'd0, o_ec}, x.ec);
   endtask

   initial begin
      logic [3:0] p;
      reset = 1'b1; din = 4'b0000; in_valid = 1'b0;

      // Clean lock, left rotation
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      step(0, 4'b1100, 1, L, 1, 0, 0, 0, 0);
      step(0, 4'b1001, 1, L, 1, 1, 0, 0, 0);
      step(0, 4'b0011, 1, L, 1, 2, 0, 0, 0);
      step(0, 4'b0110, 1, L, 1, 3, 0, 0, 0);
      step(0, 4'b1100, 1, L, 1, 0, 1, 0, 0);

      // Mismatch recovery, err drops during a stall, then degenerate mismatch drops lock
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      step(0, 4'b1100, 1, L, 1, 0, 0, 0, 0);
      step(0, 4'b1001, 1, L, 1, 1, 0, 0, 0);
      step(0, 4'b0101, 1, L, 1, 0, 0, 1, 1);
      step(0, 4'b0000, 0, L, 1, 0, 0, 0, 1);
      step(0, 4'b1010, 1, L, 1, 1, 0, 0, 1);
      step(0, 4'b1111, 1, L, 0, 0, 0, 1, 2);
      step(0, 4'b0000, 1, L, 0, 0, 0, 0, 2);

      // Degenerate input never locks
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      step(0, 4'b0000, 1, L, 0, 0, 0, 0, 0);
      step(0, 4'b1111, 1, L, 0, 0, 0, 0, 0);
      step(0, 4'b0001, 1, L, 1, 0, 0, 0, 0);

      // Stalls hold everything and checking resumes against the held reference
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      step(0, 4'b1100, 1, L, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 4'b0000, 0, L, 1, 0, 0, 0, 0);
      step(0, 4'b1001, 1, L, 1, 1, 0, 0, 0);

      // Right rotation instance
      step(1, 4'b0000, 0, R, 0, 0, 0, 0, 0);
      step(0, 4'b1000, 1, R, 1, 0, 0, 0, 0);
      step(0, 4'b0100, 1, R, 1, 1, 0, 0, 0);
      step(0, 4'b0010, 1, R, 1, 2, 0, 0, 0);
      step(0, 4'b0001, 1, R, 1, 3, 0, 0, 0);
      step(0, 4'b1000, 1, R, 1, 0, 1, 0, 0);
      step(1, 4'b0000, 0, R, 0, 0, 0, 0, 0);
      step(0, 4'b1100, 1, R, 1, 0, 0, 0, 0);
      step(0, 4'b1001, 1, R, 1, 0, 0, 1, 1);

      // Reset mid-track wins over a valid sample on the same edge
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      step(0, 4'b0001, 1, L, 1, 0, 0, 0, 0);
      step(0, 4'b0010, 1, L, 1, 1, 0, 0, 0);
      step(0, 4'b0100, 1, L, 1, 2, 0, 0, 0);
      step(0, 4'b1000, 1, L, 1, 3, 0, 0, 0);
      step(0, 4'b0001, 1, L, 1, 0, 1, 0, 0);
      step(0, 4'b0010, 1, L, 1, 1, 1, 0, 0);
      step(0, 4'b0100, 1, L, 1, 2, 1, 0, 0);
      step(1, 4'b1000, 1, L, 0, 0, 0, 0, 0);
      step(0, 4'b0011, 1, L, 1, 0, 0, 0, 0);

      // err_count saturation: 0101 never equals its own rotation
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      step(0, 4'b0101, 1, L, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 260; k++)
         step(0, 4'b0101, 1, L, 1, 0, 0, 1, (k < 255) ? k : 255);

      // rev_count wrap after 256 revolutions
      step(1, 4'b0000, 0, L, 0, 0, 0, 0, 0);
      p = 4'b0001;
      step(0, p, 1, L, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 1028; k++) begin
         p = {p[2:0], p[3]};
         step(0, p, 1, L, 1, k % 4, (k / 4) % 256, 0, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
